// File: rtl/oclib_ram1r1w_be_init.sv
// -----------------------------------------------------------------------------
// oclib_ram1r1w_be_init
//
// Purpose:
//   Flop-based simple-dual-port RAM with one write port and one read port on a
//   single clock. It provides:
//     - per-byte-lane write enables;
//     - selectable read-during-write behaviour (bypass or read-first);
//     - a read pipeline of 1..4 cycles with a valid pulse;
//     - a hardware clear sequence that fills every entry with InitValue after
//       reset and then raises ready.
//
// Ports:
//   clock        in   sole clock, rising edge
//   resetN       in   synchronous active-low reset
//   ready        out  high once the clear sequence has completed
//   write        in   write strobe (accepted only while ready)
//   writeAddress in   write address
//   writeEnable  in   per-lane write mask, bit i covers writeData lane i
//   writeData    in   write data
//   read         in   read strobe (accepted only while ready)
//   readAddress  in   read address
//   readData     out  read result, holds the last result between reads
//   readValid    out  one-cycle pulse, Latency cycles after an accepted read
// -----------------------------------------------------------------------------
module oclib_ram1r1w_be_init #(
  parameter int               Width     = 32,
  parameter int               ByteWidth = 8,
  parameter int               Depth     = 32,
  parameter int               Latency   = 1,
  parameter int               Bypass    = 1,
  parameter logic [Width-1:0] InitValue = '0
) (
  input  logic                         clock,
  input  logic                         resetN,
  output logic                         ready,
  input  logic                         write,
  input  logic [$clog2(Depth)-1:0]     writeAddress,
  input  logic [Width/ByteWidth-1:0]   writeEnable,
  input  logic [Width-1:0]             writeData,
  input  logic                         read,
  input  logic [$clog2(Depth)-1:0]     readAddress,
  output logic [Width-1:0]             readData,
  output logic                         readValid
);

  localparam int AddressWidth = $clog2(Depth);
  localparam int AddrWidthP1  = AddressWidth + 1;
  localparam int Lanes        = Width / ByteWidth;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  // Depth widened by one bit so out-of-range addresses compare correctly
  // when Depth is a power of two.
  localparam logic [AddressWidth:0]   DepthW   = AddrWidthP1'(Depth);
  localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(Depth - 1);

  // Merge new lanes over an old word according to a lane mask.
  function automatic logic [Width-1:0] f_merge(
    input logic [Width-1:0] old_word,
    input logic [Width-1:0] new_word,
    input logic [Lanes-1:0] lane_en
  );
    logic [Width-1:0] res;
    res = old_word;
    for (int l = 0; l < Lanes; l++) begin
      if (lane_en[l]) begin
        res[l*ByteWidth +: ByteWidth] = new_word[l*ByteWidth +: ByteWidth];
      end else begin
        res[l*ByteWidth +: ByteWidth] = old_word[l*ByteWidth +: ByteWidth];
      end
    end
    return res;
  endfunction

  logic [0:0]              r_state;
  logic [AddressWidth-1:0] r_clear_addr;
  logic                    r_ready;
  logic [Width-1:0]        r_mem [Depth];
  logic                    r_pipe_vld  [Latency];
  logic [Width-1:0]        r_pipe_data [Latency];

  logic                    w_wr_in_range;
  logic                    w_rd_in_range;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [Width-1:0]        w_rd_word;
  logic                    w_in_vld  [Latency];
  logic [Width-1:0]        w_in_data [Latency];

  assign w_wr_in_range = ({1'b0, writeAddress} < DepthW);
  assign w_rd_in_range = ({1'b0, readAddress} < DepthW);
  assign w_wr_acc      = write & r_ready & w_wr_in_range;
  assign w_rd_acc      = read & r_ready;

  // Clear/run sequencer: walks every address once after reset, then runs.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state      <= StClear;
      r_clear_addr <= '0;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        StClear: begin
          if (r_clear_addr == LastAddr) begin
            r_state      <= StRun;
            r_ready      <= 1'b1;
            r_clear_addr <= '0;
          end else begin
            r_clear_addr <= r_clear_addr + AddressWidth'(1);
          end
        end
        StRun: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state      <= StClear;
          r_clear_addr <= '0;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: clear writes while clearing, masked user writes while running.
  // The array is deliberately left untouched while resetN is low.
  always_ff @(posedge clock) begin
    if (resetN) begin
      if (r_state == StClear) begin
        r_mem[r_clear_addr] <= InitValue;
      end else if (w_wr_acc) begin
        r_mem[writeAddress] <= f_merge(r_mem[writeAddress], writeData, writeEnable);
      end
    end
  end

  // Word captured into the first read stage, including same-address bypass.
  always_comb begin
    w_rd_word = InitValue;
    if (w_rd_in_range) begin
      if ((Bypass != 0) && w_wr_acc && (writeAddress == readAddress)) begin
        w_rd_word = f_merge(r_mem[readAddress], writeData, writeEnable);
      end else begin
        w_rd_word = r_mem[readAddress];
      end
    end else begin
      w_rd_word = InitValue;
    end
  end

  // Input of each pipeline stage: stage 0 takes the array, others shift.
  always_comb begin
    w_in_vld[0]  = w_rd_acc;
    w_in_data[0] = w_rd_word;
    for (int i = 1; i < Latency; i++) begin
      w_in_vld[i]  = r_pipe_vld[i-1];
      w_in_data[i] = r_pipe_data[i-1];
    end
  end

  // Read pipeline; the last stage doubles as the output register and holds
  // its data between results.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < Latency; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Latency; i++) begin
        r_pipe_vld[i] <= w_in_vld[i];
        if (i == Latency - 1) begin
          if (w_in_vld[i]) begin
            r_pipe_data[i] <= w_in_data[i];
          end
        end else begin
          r_pipe_data[i] <= w_in_data[i];
        end
      end
    end
  end

  assign ready     = r_ready;
  assign readData  = r_pipe_data[Latency-1];
  assign readValid = r_pipe_vld[Latency-1];

endmodule

// File: tb/tb_oclib_ram1r1w_be_init.sv
// -----------------------------------------------------------------------------
// tb_oclib_ram1r1w_be_init
//
// Three RAM configurations share one stimulus bus:
//   inst0: Depth 20, Latency 3, bypass,     InitValue A5A5_A5A5
//   inst1: Depth 32, Latency 1, read-first, InitValue 0
//   inst2: Depth 32, Latency 2, bypass,     InitValue A5A5_A5A5
// A behavioural model (memory array plus a result calendar indexed by the
// due cycle) predicts ready/readValid/readData every cycle. On top of that
// come a directed vector table and a few hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_oclib_ram1r1w_be_init;

  localparam int NI = 3;
  localparam int          DEPTH [NI] = '{20, 32, 32};
  localparam int          LAT   [NI] = '{3, 1, 2};
  localparam int          BYP   [NI] = '{1, 0, 1};
  localparam logic [31:0] INIT  [NI] = '{32'hA5A5_A5A5, 32'h0000_0000, 32'hA5A5_A5A5};

  logic        clock;
  logic        resetN;
  logic        write;
  logic [4:0]  waddr;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic        read;
  logic [4:0]  raddr;
  logic        rdy  [NI];
  logic [31:0] rdat [NI];
  logic        rvld [NI];

  int n_checks = 0;
  int n_err    = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  oclib_ram1r1w_be_init #(
    .Width(32), .ByteWidth(8), .Depth(20), .Latency(3), .Bypass(1),
    .InitValue(32'hA5A5_A5A5)
  ) u_dut0 (
    .clock(clock), .resetN(resetN), .ready(rdy[0]),
    .write(write), .writeAddress(waddr), .writeEnable(wen), .writeData(wdata),
    .read(read), .readAddress(raddr), .readData(rdat[0]), .readValid(rvld[0])
  );

  oclib_ram1r1w_be_init #(
    .Width(32), .ByteWidth(8), .Depth(32), .Latency(1), .Bypass(0),
    .InitValue(32'h0000_0000)
  ) u_dut1 (
    .clock(clock), .resetN(resetN), .ready(rdy[1]),
    .write(write), .writeAddress(waddr), .writeEnable(wen), .writeData(wdata),
    .read(read), .readAddress(raddr), .readData(rdat[1]), .readValid(rvld[1])
  );

  oclib_ram1r1w_be_init #(
    .Width(32), .ByteWidth(8), .Depth(32), .Latency(2), .Bypass(1),
    .InitValue(32'hA5A5_A5A5)
  ) u_dut2 (
    .clock(clock), .resetN(resetN), .ready(rdy[2]),
    .write(write), .writeAddress(waddr), .writeEnable(wen), .writeData(wdata),
    .read(read), .readAddress(raddr), .readData(rdat[2]), .readValid(rvld[2])
  );

  // ---------------------------------------------------------------- model
  logic [31:0] m_mem    [NI][32];
  int          m_cnt    [NI];
  bit          m_ready  [NI];
  bit          m_slot_v [NI][8];
  logic [31:0] m_slot_d [NI][8];
  bit          m_rvld   [NI];
  logic [31:0] m_rdat   [NI];
  int          edge_n = 0;

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] en);
    logic [31:0] r;
    r = o;
    for (int l = 0; l < 4; l++) if (en[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  task automatic model_step();
    bit          acc;
    bit          wacc;
    logic [31:0] rv;
    for (int k = 0; k < NI; k++) begin
      if (!resetN) begin
        m_cnt[k]   = 0;
        m_ready[k] = 1'b0;
        m_rvld[k]  = 1'b0;
        m_rdat[k]  = 32'h0;
        for (int s = 0; s < 8; s++) m_slot_v[k][s] = 1'b0;
      end else begin
        acc  = m_ready[k];
        wacc = acc && write && (int'(waddr) < DEPTH[k]);
        if (!acc) begin
          m_mem[k][m_cnt[k]] = INIT[k];
          m_cnt[k]++;
          if (m_cnt[k] == DEPTH[k]) m_ready[k] = 1'b1;
        end
        if (acc && read) begin
          if (int'(raddr) >= DEPTH[k]) rv = INIT[k];
          else begin
            rv = m_mem[k][raddr];
            if (BYP[k] == 1 && wacc && waddr == raddr) rv = m_merge(rv, wdata, wen);
          end
          m_slot_v[k][(edge_n + LAT[k] - 1) % 8] = 1'b1;
          m_slot_d[k][(edge_n + LAT[k] - 1) % 8] = rv;
        end
        if (wacc) m_mem[k][waddr] = m_merge(m_mem[k][waddr], wdata, wen);
        if (m_slot_v[k][edge_n % 8]) begin
          m_rvld[k] = 1'b1;
          m_rdat[k] = m_slot_d[k][edge_n % 8];
          m_slot_v[k][edge_n % 8] = 1'b0;
        end else begin
          m_rvld[k] = 1'b0;
        end
      end
    end
    edge_n++;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d got %h want %h at %0t", name, k, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
        chk("ready", k, {31'd0, rdy[k]}, {31'd0, m_ready[k]});
        chk("readValid", k, {31'd0, rvld[k]}, {31'd0, m_rvld[k]});
        chk("readData", k, rdat[k], m_rdat[k]);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0; wen = 4'h0;
  endtask

  task automatic rand_ops();
    write = 1'($urandom_range(0, 1));
    waddr = 5'($urandom_range(0, 31));
    wen   = 4'($urandom_range(0, 15));
    wdata = $urandom;
    read  = 1'($urandom_range(0, 1));
    raddr = 5'($urandom_range(0, 31));
  endtask

  // Count rising edges from reset release until each ready is seen high.
  task automatic measure_clear(input bit rnd);
    int n;
    bit seen [NI];
    int cnt  [NI];
    bit all;
    n = 0;
    for (int k = 0; k < NI; k++) begin seen[k] = 1'b0; cnt[k] = -1; end
    all = 1'b0;
    while (!all && n < 200) begin
      if (rnd) rand_ops(); else idle();
      step();
      n++;
      all = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (!seen[k] && rdy[k]) begin seen[k] = 1'b1; cnt[k] = n; end
        if (!seen[k]) all = 1'b0;
      end
    end
    idle();
    for (int k = 0; k < NI; k++) chk("clear_len", k, 32'(cnt[k]), 32'(DEPTH[k]));
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) begin
      read = 1'b1; raddr = 5'(a);
      step();
    end
    idle();
    repeat (5) step();
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  wa;
    logic [3:0]  we;
    logic [31:0] wd;
    bit          rd;
    logic [4:0]  ra;
    logic [31:0] exp1;   // expected readData of inst1 after this cycle
  } vec_t;

  vec_t vt [11];

  // ---------------------------------------------------------------- main
  initial begin
    vt[0]  = '{1'b1, 5'd5,  4'b0101, 32'h1122_3344, 1'b0, 5'd0,  32'h0};
    vt[1]  = '{1'b0, 5'd0,  4'b0000, 32'h0,         1'b1, 5'd5,  32'h0022_0044};
    vt[2]  = '{1'b1, 5'd5,  4'b0000, 32'hFFFF_FFFF, 1'b1, 5'd5,  32'h0022_0044};
    vt[3]  = '{1'b0, 5'd0,  4'b0000, 32'h0,         1'b1, 5'd5,  32'h0022_0044};
    vt[4]  = '{1'b1, 5'd7,  4'b1111, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0};
    vt[5]  = '{1'b1, 5'd7,  4'b0011, 32'h0000_0000, 1'b1, 5'd7,  32'hFFFF_FFFF};
    vt[6]  = '{1'b0, 5'd0,  4'b0000, 32'h0,         1'b1, 5'd7,  32'hFFFF_0000};
    vt[7]  = '{1'b1, 5'd25, 4'b1111, 32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0};
    vt[8]  = '{1'b0, 5'd0,  4'b0000, 32'h0,         1'b1, 5'd25, 32'hDEAD_BEEF};
    vt[9]  = '{1'b1, 5'd3,  4'b1000, 32'hCAFE_F00D, 1'b1, 5'd6,  32'h0000_0000};
    vt[10] = '{1'b0, 5'd0,  4'b0000, 32'h0,         1'b1, 5'd3,  32'hCA00_0000};

    resetN = 1'b0;
    write  = 1'b0; waddr = 5'd0; wen = 4'h0; wdata = 32'h0;
    read   = 1'b0; raddr = 5'd0;
    repeat (3) step();
    for (int k = 0; k < NI; k++) begin
      chk("rst_ready", k, {31'd0, rdy[k]}, 32'd0);
      chk("rst_rvalid", k, {31'd0, rvld[k]}, 32'd0);
      chk("rst_rdata", k, rdat[k], 32'h0);
    end

    // Clear with ignored ops during ready=0, then read everything back.
    resetN = 1'b1;
    measure_clear(1'b1);
    read_all();

    // Reset mid-clear after ten clear writes.
    resetN = 1'b0; step(); resetN = 1'b1;
    repeat (10) step();
    resetN = 1'b0; step(); resetN = 1'b1;
    measure_clear(1'b1);
    read_all();

    // Reset in RUN with two reads in flight on the Latency-3 instance.
    read = 1'b1; raddr = 5'd3; step();
    raddr = 5'd4; step();
    idle();
    resetN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_rvalid", 0, {31'd0, rvld[0]}, 32'd0);
      chk("drop_ready", 0, {31'd0, rdy[0]}, 32'd0);
    end
    resetN = 1'b1;
    measure_clear(1'b0);

    // Directed vectors; inst1 has Latency 1, so its result is visible after one edge.
    for (int i = 0; i < 11; i++) begin
      write = vt[i].wr; waddr = vt[i].wa; wen = vt[i].we; wdata = vt[i].wd;
      read  = vt[i].rd; raddr = vt[i].ra;
      step();
      if (vt[i].rd) begin
        chk("vec_rvalid", 1, {31'd0, rvld[1]}, 32'd1);
        chk("vec_rdata", 1, rdat[1], vt[i].exp1);
      end
    end
    idle();
    repeat (4) step();

    // Throughput on the Latency-3 instance, with a write to addr 1 after its read.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin read = 1'b1; raddr = 5'(i); end else read = 1'b0;
      if (i == 2) begin write = 1'b1; waddr = 5'd1; wen = 4'hF; wdata = 32'h1234_5678; end
      else write = 1'b0;
      step();
      chk("thru_rvalid", 0, {31'd0, rvld[0]}, (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
    end
    idle();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      resetN = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step();
    end
    resetN = 1'b1;
    idle();
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/oclib_ram1r1w_be_init.md
Name: oclib_ram1r1w_be_init

Overview:
- Next-generation simple-dual-port RAM: one write port, one read port, one clock.
- Adds per-byte write enables, configurable read-during-write behaviour (bypass or read-first), a read-valid pipeline, and a hardware clear-on-reset sequencer with a ready flag.
- Used by queues, tables and CSR shadows that need a known initial content without a software init loop.
- Implemented on flops; all writes occur on posedge, with no negedge tricks.

Parameters:
- Width, 32: data bits; must be a multiple of ByteWidth.
- ByteWidth, 8: bits per write-enable lane; Lanes = Width/ByteWidth.
- Depth, 32: entries, from 2 to 4096, not required to be a power of 2. AddressWidth = $clog2(Depth).
- Latency, 1: read latency in cycles, from 1 to 4.
- Bypass, 1: 1 means a same-cycle same-address read returns merged new data; 0 means read-first (old data).
- InitValue, '0: Width-bit value written to every entry during the clear sequence.

Ports:
- clock, in, 1: sole clock, rising edge.
- resetN, in, 1: synchronous active-low reset.
- ready, out, 1: high once the clear sequence is complete; user ops are accepted only while ready=1.
- write, in, 1: write strobe.
- writeAddress, in, AddressWidth: write address.
- writeEnable, in, Lanes: per-lane write mask; bit i covers writeData[i*ByteWidth +: ByteWidth].
- writeData, in, Width: write data.
- read, in, 1: read strobe.
- readAddress, in, AddressWidth: read address.
- readData, out, Width: read result.
- readValid, out, 1: one-cycle pulse, exactly Latency cycles after an accepted read.

Behaviour:
- Reset (resetN=0 at a posedge):
  - FSM goes to CLEAR; clearAddr=0.
  - ready=0, readValid=0, readData=0; all pipeline valids = 0.
  - Memory contents are not touched during reset itself.
- CLEAR state:
  - Each cycle writes InitValue to mem[clearAddr] (all lanes), then clearAddr++.
  - After the write to Depth-1, FSM goes to RUN and ready=1 on the next cycle. The clear takes exactly Depth cycles from the first cycle with resetN=1.
  - User write/read are ignored in CLEAR: no memory change, no readValid.
- RUN state:
  - ready stays 1 until the next reset.
  - Reassertion of resetN=0 mid-RUN or mid-CLEAR restarts CLEAR from address 0; in-flight reads are dropped (valids cleared).
- Write:
  - Accepted when write & ready.
  - At posedge: for each lane i with writeEnable[i]=1, mem[writeAddress] lane i <= writeData lane i; other lanes are unchanged.
  - writeEnable=0 with write=1 is a legal no-op.
- Read:
  - Accepted when read & ready.
  - Stage 0 captures the array word at readAddress at the posedge.
  - If Bypass=1 and an accepted write targets the same address in the same cycle, stage 0 captures the merge: enabled lanes from writeData, other lanes from mem.
  - If Bypass=0, stage 0 captures pre-write contents.
- Pipeline:
  - Stages 1..Latency-1 shift every cycle. Data is held in the pipe, so later writes never alter an in-flight read.
  - readData updates only when the last stage holds a valid read, and otherwise holds the last read value (0 after reset).
  - readValid is high for exactly the cycle readData presents a new result.
  - Back-to-back reads every cycle give back-to-back readValid with full throughput.
- Out-of-range addresses (address >= Depth, possible when Depth is not a power of 2):
  - A write is ignored.
  - A read returns InitValue with readValid asserted.
- Simultaneous read and write to different addresses are independent.

Test Plan:
- Clear sequence: Depth=32, hold resetN=0 for 3 cycles, then release -> ready=0 for exactly 32 cycles, then 1. Read all 32 addresses with InitValue=32'hA5A5_A5A5 -> every readData = A5A5_A5A5, and each readValid arrives Latency cycles after its read.
- Byte-masked write: write addr 5, data 32'h1122_3344, writeEnable=4'b0101 over InitValue 0 -> read addr 5 returns 32'h0022_0044. Repeat with writeEnable=4'b0000 -> contents unchanged.
- Read-during-write: mem[7]=32'hFFFF_FFFF; in the same cycle write addr 7, data 0, writeEnable=4'b0011, and read addr 7. Bypass=1 -> 32'hFFFF_0000. Bypass=0 -> 32'hFFFF_FFFF, and a following read -> 32'hFFFF_0000.
- Latency/throughput with Latency=3: reads to addresses 0,1,2,3 on 4 consecutive cycles -> readValid high for 4 consecutive cycles starting 3 cycles after the first read, with data in order. A write to addr 1 one cycle after its read does not change the returned value.
- Reset mid-operation: assert resetN=0 during CLEAR at clearAddr=10, and again in RUN with 2 reads in flight -> no readValid is produced for the dropped reads, ready falls, and the full Depth-cycle clear reruns from address 0.
- Non-power-of-2 depth and ignored ops, Depth=20: a write to addr 25 does not alias into any entry, and a read of addr 25 returns InitValue. Writes and reads issued while ready=0 cause no memory change and no readValid.
